// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program counter.
// Alignment fault detection is enabled by defining PC_ALIGN_CHECK_EN.
package pc_pkg;

  typedef enum logic [2:0] {
    S_RESET = 3'b000,
    S_BOOT  = 3'b001,
    S_RUN   = 3'b010,
    S_STALL = 3'b011,
    S_HALT  = 3'b100,
    S_FAULT = 3'b101
  } pc_state_e;

  typedef struct packed {
    logic active;
    logic fetch_stall;
  } pc_status_t;

  localparam logic [31:0] RESET_VECTOR_C = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_C    = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_C      = 32'd4;

  // Status outputs implied by the state being entered.
  function automatic pc_status_t pc_status(input pc_state_e s);
    pc_status_t st;
    st.active      = 1'b0;
    st.fetch_stall = 1'b1;
    case (s)
      S_BOOT:  st.active = 1'b1;
      S_RUN:   begin st.active = 1'b1; st.fetch_stall = 1'b0; end
      S_STALL: st.active = 1'b1;
      default: ;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC / next-state selection for the program counter.
// With PC_ALIGN_CHECK_EN defined, misaligned redirects enter FAULT; otherwise they are forced aligned.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_C,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_C,
  parameter logic [31:0] PC_STEP      = PC_STEP_C
) (
  input  pc_state_e   state,
  input  logic [31:0] pc,
  input  logic [31:0] PC_JVal,
  input  logic        jump_en,
  input  logic        branch_en,
  input  logic        PC_Stall,
  output pc_state_e   next_state,
  output logic [31:0] next_pc
);

  logic        redirect;
  logic [31:0] target;

  always_comb begin
    redirect   = jump_en | branch_en;
`ifdef PC_ALIGN_CHECK_EN
    target     = PC_JVal;
`else
    target     = {PC_JVal[31:2], 2'b00};
`endif
    next_state = state;
    next_pc    = pc;
    case (state)
      S_RESET: begin
        next_state = S_BOOT;
        next_pc    = RESET_VECTOR;
      end
      S_BOOT: begin
        next_state = S_RUN;
        next_pc    = RESET_VECTOR;
      end
      S_RUN, S_STALL: begin
        // Stall outranks redirect: decode must keep the redirect asserted.
        if (PC_Stall) begin
          next_state = S_STALL;
        end else if (redirect) begin
          if (PC_JVal == HALT_ADDR) begin
            next_state = S_HALT;
            next_pc    = HALT_ADDR;
`ifdef PC_ALIGN_CHECK_EN
          end else if (PC_JVal[1:0] != 2'b00) begin
            next_state = S_FAULT;
`endif
          end else begin
            next_state = S_RUN;
            next_pc    = target;
          end
        end else begin
          next_state = S_RUN;
          next_pc    = pc + PC_STEP;
        end
      end
      S_HALT, S_FAULT: ;
      default: begin
        next_state = S_RESET;
        next_pc    = RESET_VECTOR;
      end
    endcase
  end

endmodule

// File: rtl/program_counter.sv
// Fetch-stage program counter: state/PC registers with registered status decode.
// Optional alignment checking is selected by defining PC_ALIGN_CHECK_EN.
module program_counter
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_C,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_C,
  parameter logic [31:0] PC_STEP      = PC_STEP_C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_JVal,
  input  logic        jump_en,
  input  logic        branch_en,
  input  logic        PC_Stall,
  output logic [31:0] PC_Out,
  output logic        fetch_stall,
  output logic        active,
  output logic [2:0]  check
);

  pc_state_e   state;
  pc_state_e   next_state;
  logic [31:0] next_pc;
  pc_status_t  next_status;

  pc_next_sel #(
    .RESET_VECTOR (RESET_VECTOR),
    .HALT_ADDR    (HALT_ADDR),
    .PC_STEP      (PC_STEP)
  ) u_next_sel (
    .state      (state),
    .pc         (PC_Out),
    .PC_JVal    (PC_JVal),
    .jump_en    (jump_en),
    .branch_en  (branch_en),
    .PC_Stall   (PC_Stall),
    .next_state (next_state),
    .next_pc    (next_pc)
  );

  always_comb next_status = pc_status(next_state);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RESET;
      PC_Out      <= RESET_VECTOR;
      active      <= 1'b0;
      fetch_stall <= 1'b1;
    end else begin
      state       <= next_state;
      PC_Out      <= next_pc;
      active      <= next_status.active;
      fetch_stall <= next_status.fetch_stall;
    end
  end

  assign check = state;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter using an expected-result scoreboard queue.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC_JVal = '0;
  logic        jump_en = 1'b0;
  logic        branch_en = 1'b0;
  logic        PC_Stall = 1'b0;
  logic [31:0] PC_Out;
  logic        fetch_stall;
  logic        active;
  logic [2:0]  check;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  st;
    logic        fs;
    logic        act;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] RV = 32'hBFC0_0000;

  program_counter #(
    .RESET_VECTOR (32'hBFC0_0000),
    .HALT_ADDR    (32'h0000_0000),
    .PC_STEP      (32'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .PC_JVal     (PC_JVal),
    .jump_en     (jump_en),
    .branch_en   (branch_en),
    .PC_Stall    (PC_Stall),
    .PC_Out      (PC_Out),
    .fetch_stall (fetch_stall),
    .active      (active),
    .check       (check)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic step(input logic r, input logic [31:0] jv, input logic j, input logic b,
                      input logic s, input logic [31:0] e_pc, input logic [2:0] e_st,
                      input logic e_fs, input logic e_act, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r; PC_JVal = jv; jump_en = j; branch_en = b; PC_Stall = s;
    e.pc = e_pc; e.st = e_st; e.fs = e_fs; e.act = e_act;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_val({tag, ".pc"}, PC_Out, e.pc);
    check_val({tag, ".check"}, {29'd0, check}, {29'd0, e.st});
    check_val({tag, ".fs"}, {31'd0, fetch_stall}, {31'd0, e.fs});
    check_val({tag, ".active"}, {31'd0, active}, {31'd0, e.act});
  endtask

  task automatic idle(input logic [31:0] e_pc, input string tag);
    step(0, 32'h0, 0, 0, 0, e_pc, 3'b010, 0, 1, tag);
  endtask

  task automatic do_reset_boot();
    step(1, 32'h0, 0, 0, 0, RV, 3'b000, 1, 0, "rst");
    step(0, 32'h0, 0, 0, 0, RV, 3'b001, 1, 1, "boot");
    step(0, 32'h0, 0, 0, 0, RV, 3'b010, 0, 1, "run0");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++)
      step(1, 32'h0, 0, 0, 0, RV, 3'b000, 1, 0, "rst_hold");
    step(0, 32'h0, 0, 0, 0, RV, 3'b001, 1, 1, "boot");
    step(0, 32'h0, 0, 0, 0, RV, 3'b010, 0, 1, "run0");
    idle(32'hBFC0_0004, "inc1");
    idle(32'hBFC0_0008, "inc2");
    idle(32'hBFC0_000C, "inc3");
    step(0, 32'h0, 0, 0, 1, 32'hBFC0_000C, 3'b011, 1, 1, "stall");
    idle(32'hBFC0_0010, "unstall");

    step(0, 32'hBFC0_0100, 1, 0, 0, 32'hBFC0_0100, 3'b010, 0, 1, "jump");
    idle(32'hBFC0_0104, "jump_inc");
    step(0, 32'hBFC0_0200, 0, 1, 0, 32'hBFC0_0200, 3'b010, 0, 1, "branch");
    idle(32'hBFC0_0204, "branch_inc");
    step(0, 32'hBFC0_0300, 1, 1, 0, 32'hBFC0_0300, 3'b010, 0, 1, "both");
    idle(32'hBFC0_0304, "both_inc");

    step(0, 32'hBFC0_0400, 1, 0, 1, 32'hBFC0_0304, 3'b011, 1, 1, "jstall1");
    step(0, 32'hBFC0_0400, 1, 0, 1, 32'hBFC0_0304, 3'b011, 1, 1, "jstall2");
    step(0, 32'hBFC0_0400, 1, 0, 0, 32'hBFC0_0400, 3'b010, 0, 1, "jrelease");
    idle(32'hBFC0_0404, "jrel_inc");

`ifdef PC_ALIGN_CHECK_EN
    step(0, 32'hBFC0_0102, 1, 0, 0, 32'hBFC0_0404, 3'b101, 1, 0, "misalign");
    step(0, 32'hBFC0_0500, 1, 0, 0, 32'hBFC0_0404, 3'b101, 1, 0, "fault_hold");
    step(0, 32'h0, 0, 0, 1, 32'hBFC0_0404, 3'b101, 1, 0, "fault_stall");
`else
    step(0, 32'hBFC0_0102, 1, 0, 0, 32'hBFC0_0100, 3'b010, 0, 1, "misalign");
    idle(32'hBFC0_0104, "misalign_inc");
`endif
    do_reset_boot();
    idle(32'hBFC0_0004, "post_rst_inc");

    step(0, 32'h0, 1, 0, 0, 32'h0, 3'b100, 1, 0, "halt");
    step(0, 32'hBFC0_0500, 1, 0, 0, 32'h0, 3'b100, 1, 0, "halt_jump");
    step(0, 32'hBFC0_0500, 0, 1, 1, 32'h0, 3'b100, 1, 0, "halt_stall");
    step(0, 32'h0, 0, 0, 0, 32'h0, 3'b100, 1, 0, "halt_idle");
    do_reset_boot();

    step(0, 32'hFFFF_FFF8, 1, 0, 0, 32'hFFFF_FFF8, 3'b010, 0, 1, "to_top");
    idle(32'hFFFF_FFFC, "top");
    idle(32'h0000_0000, "wrap");
    idle(32'h0000_0004, "wrap_inc");

    step(0, 32'h0, 0, 0, 1, 32'h0000_0004, 3'b011, 1, 1, "stall_pre_rst");
    step(1, 32'h0, 0, 0, 1, RV, 3'b000, 1, 0, "rst_in_stall");
    step(0, 32'h0, 0, 0, 0, RV, 3'b001, 1, 1, "boot2");

    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard: got %0d leftover expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
